// File: rtl/avsdbgp_en_sequencer.sv
// Power-up sequencer for the avsdbgp bandgap: drives EN, waits out settling,
// confirms VBGP via a synchronised comparator flag and enforces a minimum off time.
module avsdbgp_en_sequencer #(
  parameter int SETTLE_CYCLES   = 1000,
  parameter int OK_TIMEOUT      = 256,
  parameter int COOLDOWN_CYCLES = 64,
  parameter int DROP_FILT       = 4,
  parameter int CNT_W           = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       req_on,
  input  logic       vref_ok,
  input  logic       fault_clr,
  output logic       bgp_en,
  output logic       ready,
  output logic       fault,
  output logic       irq,
  output logic [2:0] state
);

  localparam int DROP_W = $clog2(DROP_FILT + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OK_LAST     = CNT_W'(OK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  COOL_LAST   = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [DROP_W-1:0] DROP_LIMIT  = DROP_W'(DROP_FILT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLE   = 3'd1,
    S_CHECK    = 3'd2,
    S_READY    = 3'd3,
    S_COOLDOWN = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [DROP_W-1:0] r_drop;
  logic [DROP_W-1:0] w_drop_next;
  logic [DROP_W-1:0] w_drop_inc;
  logic              r_vref_meta;
  logic              r_vref_s;
  logic              r_bgp_en;
  logic              r_ready;
  logic              r_fault;
  logic              r_irq;
  logic              w_state_change;
  logic              w_counting;

  // Comparator flag is asynchronous to the bus clock.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_vref_meta <= 1'b0;
      r_vref_s    <= 1'b0;
    end else begin
      r_vref_meta <= vref_ok;
      r_vref_s    <= r_vref_meta;
    end
  end

  assign w_drop_inc = r_drop + DROP_W'(1);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_on) w_state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (!req_on)                   w_state_next = S_COOLDOWN;
        else if (r_cnt == SETTLE_LAST) w_state_next = S_CHECK;
      end
      S_CHECK: begin
        if (!req_on)               w_state_next = S_COOLDOWN;
        else if (r_vref_s)         w_state_next = S_READY;
        else if (r_cnt == OK_LAST) w_state_next = S_FAULT;
      end
      S_READY: begin
        if (!req_on)                                   w_state_next = S_COOLDOWN;
        else if (!r_vref_s && w_drop_inc == DROP_LIMIT) w_state_next = S_FAULT;
      end
      S_COOLDOWN: begin
        if (r_cnt == COOL_LAST) w_state_next = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clr) w_state_next = S_COOLDOWN;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_state_change = (w_state_next != r_state);
  assign w_counting     = (r_state == S_SETTLE) || (r_state == S_CHECK) ||
                          (r_state == S_COOLDOWN);

  // Both counters restart on every transition, so neither can wrap.
  always_comb begin
    w_cnt_next  = '0;
    w_drop_next = '0;
    if (!w_state_change && w_counting) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
    if (!w_state_change && (r_state == S_READY) && !r_vref_s) begin
      w_drop_next = w_drop_inc;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_drop   <= '0;
      r_bgp_en <= 1'b0;
      r_ready  <= 1'b0;
      r_fault  <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_drop   <= w_drop_next;
      r_bgp_en <= (w_state_next == S_SETTLE) || (w_state_next == S_CHECK) ||
                  (w_state_next == S_READY);
      r_ready  <= (w_state_next == S_READY);
      r_fault  <= (w_state_next == S_FAULT);
      r_irq    <= w_state_change &&
                  ((w_state_next == S_READY) || (w_state_next == S_FAULT));
    end
  end

  assign bgp_en = r_bgp_en;
  assign ready  = r_ready;
  assign fault  = r_fault;
  assign irq    = r_irq;
  assign state  = r_state;

endmodule

// File: tb/tb_avsdbgp_en_sequencer.sv
// Bench for avsdbgp_en_sequencer: directed power-up scenarios plus random
// stimulus, every cycle compared against a time-in-state reference model.
module tb_avsdbgp_en_sequencer;

  localparam int SETTLE = 8;
  localparam int TMO    = 4;
  localparam int COOL   = 3;
  localparam int DROP   = 2;

  logic       wb_clk_i  = 1'b0;
  logic       wb_rst_i  = 1'b1;
  logic       req_on    = 1'b0;
  logic       vref_ok   = 1'b0;
  logic       fault_clr = 1'b0;
  logic       bgp_en;
  logic       ready;
  logic       fault;
  logic       irq;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int irq_seen = 0;
  int ready_seen = 0;

  // Reference model: phase name, cycles spent in it, consecutive-low run,
  // and the two-sample history of the comparator flag.
  int m_st;
  int m_t;
  int m_low;
  bit m_meta;
  bit m_vs;
  bit m_irq;

  avsdbgp_en_sequencer #(
    .SETTLE_CYCLES  (SETTLE),
    .OK_TIMEOUT     (TMO),
    .COOLDOWN_CYCLES(COOL),
    .DROP_FILT      (DROP),
    .CNT_W          (8)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .req_on   (req_on),
    .vref_ok  (vref_ok),
    .fault_clr(fault_clr),
    .bgp_en   (bgp_en),
    .ready    (ready),
    .fault    (fault),
    .irq      (irq),
    .state    (state)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_t = 0; m_low = 0; m_meta = 0; m_vs = 0; m_irq = 0;
  endtask

  task automatic model_step();
    int nxt;
    nxt = m_st;
    case (m_st)
      0: if (req_on) nxt = 1;
      1: begin
        if (!req_on) nxt = 4;
        else if (m_t + 1 == SETTLE) nxt = 2;
      end
      2: begin
        if (!req_on) nxt = 4;
        else if (m_vs) nxt = 3;
        else if (m_t + 1 == TMO) nxt = 5;
      end
      3: begin
        m_low = m_vs ? 0 : m_low + 1;
        if (!req_on) nxt = 4;
        else if (m_low >= DROP) nxt = 5;
      end
      4: if (m_t + 1 == COOL) nxt = 0;
      5: if (fault_clr) nxt = 4;
      default: nxt = 0;
    endcase
    m_irq = (nxt != m_st) && (nxt == 3 || nxt == 5);
    if (nxt != m_st) begin
      m_t = 0;
      m_low = 0;
    end else begin
      m_t++;
    end
    m_vs   = m_meta;
    m_meta = vref_ok;
    m_st   = nxt;
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    model_step();
    #1;
    if (irq) irq_seen++;
    if (ready) ready_seen++;
    check("state",  int'(state),  m_st);
    check("bgp_en", int'(bgp_en), (m_st >= 1 && m_st <= 3) ? 1 : 0);
    check("ready",  int'(ready),  (m_st == 3) ? 1 : 0);
    check("fault",  int'(fault),  (m_st == 5) ? 1 : 0);
    check("irq",    int'(irq),    int'(m_irq));
  endtask

  function automatic int sig(input int sel);
    case (sel)
      0:       return int'(bgp_en);
      1:       return int'(ready);
      2:       return int'(fault);
      default: return int'(state);
    endcase
  endfunction

  // Clocks until the selected output reaches want; n saturates at bound.
  task automatic ticks_until(input int sel, input int want, input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sig(sel) != want && n < bound);
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    model_reset();
    #1;
    check("rst_state",  int'(state),  0);
    check("rst_bgp_en", int'(bgp_en), 0);
    check("rst_ready",  int'(ready),  0);
    check("rst_fault",  int'(fault),  0);
    check("rst_irq",    int'(irq),    0);
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_seq[5];
    exp_seq = '{4, 4, 4, 0, 1};

    // Nominal power-up
    vref_ok = 1'b1;
    do_reset();
    req_on = 1'b1;
    irq_seen = 0;
    tick();
    check("t1_en_lat", int'(bgp_en), 1);
    ticks_until(1, 1, 40, n);
    check("t1_ready_lat", n, SETTLE + 1);
    check("t1_state_ready", int'(state), 3);
    repeat (3) tick();
    check("t1_irq_count", irq_seen, 1);
    $display("scenario 1 nominal power-up: ready after %0d cycles", n);

    // Timeout into FAULT, then clear
    req_on = 1'b0;
    vref_ok = 1'b0;
    repeat (6) tick();
    check("t2_idle", int'(state), 0);
    req_on = 1'b1;
    tick();
    check("t2_en_rise", int'(bgp_en), 1);
    irq_seen = 0;
    ticks_until(2, 1, 40, n);
    check("t2_fault_lat", n, SETTLE + TMO);
    check("t2_en_off", int'(bgp_en), 0);
    repeat (3) tick();
    check("t2_fault_hold", int'(fault), 1);
    check("t2_irq_count", irq_seen, 1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("t2_clr_seq0", int'(state), exp_seq[0]);
    for (int i = 1; i < 5; i++) begin
      tick();
      check("t2_clr_seq", int'(state), exp_seq[i]);
    end
    $display("scenario 2 timeout: fault after %0d cycles", n);

    // Drop filter
    vref_ok = 1'b1;
    ticks_until(1, 1, 40, n);
    check("t3_ready", int'(ready), 1);
    vref_ok = 1'b0;
    tick();
    vref_ok = 1'b1;
    repeat (6) tick();
    check("t3_glitch_fault", int'(fault), 0);
    check("t3_glitch_ready", int'(ready), 1);
    vref_ok = 1'b0;
    ticks_until(2, 1, 20, n);
    check("t3_drop_lat", n, 4);
    $display("scenario 3 drop filter: fault %0d cycles after vref_ok fall", n);

    // Abort during SETTLE with cooldown
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    vref_ok = 1'b1;
    ticks_until(0, 1, 20, n);
    check("t4_settle", int'(state), 1);
    repeat (5) tick();
    req_on = 1'b0;
    tick();
    check("t4_en_off", int'(bgp_en), 0);
    req_on = 1'b1;
    ticks_until(0, 1, 20, n);
    check("t4_low_time", n, COOL + 1);
    $display("scenario 4 abort: bgp_en low for %0d cycles", n);

    // req_on fall coincides with vref_ok_s rise in CHECK
    req_on = 1'b0;
    vref_ok = 1'b0;
    repeat (6) tick();
    req_on = 1'b1;
    irq_seen = 0;
    ready_seen = 0;
    tick();
    repeat (6) tick();
    vref_ok = 1'b1;
    tick();
    tick();
    check("t5_in_check", int'(state), 2);
    req_on = 1'b0;
    tick();
    check("t5_cooldown", int'(state), 4);
    check("t5_ready", int'(ready), 0);
    repeat (3) tick();
    check("t5_irq_none", irq_seen, 0);
    check("t5_ready_none", ready_seen, 0);
    $display("scenario 5 simultaneous: state %0d", int'(state));

    // Asynchronous reset from READY
    req_on = 1'b1;
    ticks_until(1, 1, 40, n);
    check("t6_ready", int'(ready), 1);
    #1;
    wb_rst_i = 1'b1;
    model_reset();
    #1;
    check("t6_async_en", int'(bgp_en), 0);
    check("t6_async_ready", int'(ready), 0);
    check("t6_async_state", int'(state), 0);
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    tick();
    check("t6_settle", int'(state), 1);
    check("t6_en", int'(bgp_en), 1);
    $display("scenario 6 async reset: state %0d after release", int'(state));

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19) == 0) req_on = ~req_on;
      if ($urandom_range(5) == 0) vref_ok = ~vref_ok;
      fault_clr = ($urandom_range(7) == 0);
      tick();
    end
    fault_clr = 1'b0;
    $display("random phase: 4000 cycles");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
